// File: rtl/vec_pkg.sv
// Shared defaults and FSM state type for the vector serializer.
package vec_pkg;

  localparam int VEC_BITS = 8;
  localparam int VEC_N    = 64;

  typedef enum logic [2:0] {
    IDLE,
    SEND_LEN,
    SEND_DATA,
`ifdef VEC_SERIAL_OUT_CHECKSUM_EN
    SEND_SUM,
`endif
    FIN
  } vec_ser_state_t;

endpackage

// File: rtl/vec_serial_out.sv
// Serializes a snapshot vector as length, data beats and, when
// VEC_SERIAL_OUT_CHECKSUM_EN is defined, a trailing XOR checksum beat.
module vec_serial_out
  import vec_pkg::*;
#(
  parameter int BITS = VEC_BITS,
  parameter int N    = VEC_N
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] in [N-1:0],
  input  logic [BITS-1:0] in_len,
  input  logic            start,
  input  logic            out_ready,
  output logic [BITS-1:0] out,
  output logic            out_valid,
  output logic            busy,
  output logic            done,
  output logic            len_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  vec_ser_state_t  state;
  logic [BITS-1:0] vec [N-1:0];
  logic [BITS-1:0] length;
  logic [IW:0]     index;
  logic [IW:0]     index_nxt;
  logic            fire;
  logic            last;
  logic            clamp;
  logic [BITS-1:0] len_cap;
`ifdef VEC_SERIAL_OUT_CHECKSUM_EN
  logic [BITS-1:0] sum;
  logic [BITS-1:0] sum_nxt;
`endif

  always_comb begin
    fire      = out_valid & out_ready;
    last      = (int'(index) + 1 == int'(length));
    clamp     = (int'(in_len) > N);
    len_cap   = clamp ? BITS'(N) : in_len;
    index_nxt = index + 1'b1;
`ifdef VEC_SERIAL_OUT_CHECKSUM_EN
    // running XOR includes the beat being accepted now
    sum_nxt   = sum ^ out;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      len_err   <= 1'b0;
      index     <= '0;
      length    <= '0;
      for (int i = 0; i < N; i++)
        vec[i] <= '0;
`ifdef VEC_SERIAL_OUT_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            vec       <= in;
            length    <= len_cap;
            index     <= '0;
            out       <= len_cap;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND_LEN;
            if (clamp)
              len_err <= 1'b1;
`ifdef VEC_SERIAL_OUT_CHECKSUM_EN
            sum       <= '0;
`endif
          end
        end
        SEND_LEN: begin
          if (fire) begin
`ifdef VEC_SERIAL_OUT_CHECKSUM_EN
            sum <= sum_nxt;
`endif
            if (length == '0) begin
`ifdef VEC_SERIAL_OUT_CHECKSUM_EN
              out       <= sum_nxt;
              state     <= SEND_SUM;
`else
              out       <= '0;
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= FIN;
`endif
            end else begin
              index <= '0;
              out   <= vec[0];
              state <= SEND_DATA;
            end
          end
        end
        SEND_DATA: begin
          if (fire) begin
`ifdef VEC_SERIAL_OUT_CHECKSUM_EN
            sum <= sum_nxt;
`endif
            if (last) begin
`ifdef VEC_SERIAL_OUT_CHECKSUM_EN
              out       <= sum_nxt;
              state     <= SEND_SUM;
`else
              out       <= '0;
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= FIN;
`endif
            end else begin
              index <= index_nxt;
              out   <= vec[index_nxt[IW-1:0]];
            end
          end
        end
`ifdef VEC_SERIAL_OUT_CHECKSUM_EN
        SEND_SUM: begin
          if (fire) begin
            out       <= '0;
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= FIN;
          end
        end
`endif
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          out       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_serial_out.sv
// Randomized bench for vec_serial_out against a queue-based stream model.
module tb_vec_serial_out;
  import vec_pkg::*;

  localparam int BITS = VEC_BITS;
  localparam int N    = VEC_N;

  logic            clk = 1'b0;
  logic            rst;
  logic [BITS-1:0] vin [N-1:0];
  logic [BITS-1:0] vlen;
  logic            start;
  logic            out_ready;
  logic [BITS-1:0] out;
  logic            out_valid;
  logic            busy;
  logic            done;
  logic            len_err;

  logic [BITS-1:0] src [N-1:0];
  int n_chk  = 0;
  int n_fail = 0;

  vec_serial_out #(.BITS(BITS), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (vin),
    .in_len    (vlen),
    .start     (start),
    .out_ready (out_ready),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rand_src();
    foreach (src[i]) src[i] = BITS'($urandom);
  endtask

  // Expected stream: clamped length, elements, optional XOR.
  // rst_at >= 0 asserts reset once that many beats were accepted.
  task automatic run_stream(input int len, input int rdy_pct,
                            input int rst_at);
    logic [BITS-1:0] q[$];
    logic [BITS-1:0] acc;
    logic [BITS-1:0] held;
    logic            stalled;
    logic            fin;
    int              l;
    int              beats;
    l = (len > N) ? N : len;
    q.push_back(BITS'(l));
    acc = BITS'(l);
    for (int i = 0; i < l; i++) begin
      q.push_back(src[i]);
      acc ^= src[i];
    end
`ifdef VEC_SERIAL_OUT_CHECKSUM_EN
    q.push_back(acc);
`endif
    @(negedge clk);
    vin       = src;
    vlen      = BITS'(len);
    start     = 1'b1;
    out_ready = ($urandom_range(99) < rdy_pct);
    @(negedge clk);
    start = 1'b0;
    chk("busy_on", 32'(busy), 1);
    chk("latency", 32'(out_valid), 1);
    stalled = 1'b0;
    fin     = 1'b0;
    beats   = 0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (stalled) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out), 32'(held));
      end
      if (rst_at >= 0 && beats == rst_at) begin
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_out", 32'(out), 0);
        chk("rst_lerr", 32'(len_err), 0);
        rst = 1'b0;
        return;
      end
      if (done) begin
        start = 1'b0;
        chk("done_left", q.size(), 0);
        chk("fin_valid", 32'(out_valid), 0);
        chk("fin_out", 32'(out), 0);
        fin = 1'b1;
      end else begin
        out_ready = ($urandom_range(99) < rdy_pct);
        if ($urandom_range(3) == 0) begin
          start = 1'($urandom_range(1));
          vlen  = BITS'($urandom);
          foreach (vin[i]) vin[i] = BITS'($urandom);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0)
            chk("extra_beat", 1, 0);
          else
            chk("beat", 32'(out), 32'(q.pop_front()));
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = out_valid;
          held    = out;
        end
      end
    end
    if (!fin) begin
      chk("timeout", 0, 1);
    end else begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("done_pulse", 32'(done), 0);
      chk("idle_out", 32'(out), 0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    vlen      = '0;
    foreach (vin[i]) vin[i] = '0;
    foreach (src[i]) src[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_lerr", 32'(len_err), 0);
    chk("reset_out", 32'(out), 0);

    rand_src();
    src[0] = 5; src[1] = 6; src[2] = 7;
    run_stream(3, 100, -1);

    rand_src();
    run_stream(2, 50, -1);

    rand_src();
    run_stream(0, 100, -1);
    chk("no_lerr", 32'(len_err), 0);

    rand_src();
    run_stream(N + 5, 100, -1);
    chk("lerr_set", 32'(len_err), 1);
    rand_src();
    run_stream(4, 70, -1);
    chk("lerr_hold", 32'(len_err), 1);

    rand_src();
    run_stream(5, 100, 3);
    rand_src();
    run_stream(3, 100, -1);

    rand_src();
    src[0] = 8'h0F; src[1] = 8'hF0;
    run_stream(2, 100, -1);

    for (int t = 0; t < 25; t++) begin
      rand_src();
      if ($urandom_range(4) == 0)
        run_stream($urandom_range(255), $urandom_range(100, 20), -1);
      else
        run_stream($urandom_range(N), $urandom_range(100, 20), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_serial_out.md
VEC_SERIAL_OUT -- requirements
Module: vec_serial_out

Interface
REQ-001 Parameter BITS, default 8, element and length width in bits.
REQ-002 Parameter N, default 64, maximum vector elements.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in  input  BITS x N (unpacked [N-1:0])  parallel source vector.
REQ-006 in_len  input  BITS  number of valid elements in in.
REQ-007 start  input  1  request to serialize in/in_len.
REQ-008 out_ready  input  1  downstream accepts a beat this cycle.
REQ-009 out  output  BITS  serialized beat data.
REQ-010 out_valid  output  1  out holds a valid beat.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse after the last beat is accepted.
REQ-013 len_err  output  1  sticky flag: an in_len greater than N was clamped.

Function
REQ-014 FSM states SHALL be IDLE, SEND_LEN, SEND_DATA, SEND_SUM and FIN; SEND_SUM exists only per REQ-028.
REQ-015 In IDLE, start=1 SHALL snapshot in into an internal vector and min(in_len,N) into an internal length, then go to SEND_LEN on the next cycle.
REQ-016 When in_len>N is captured, len_err SHALL set and hold until rst.
REQ-017 A beat transfers only on a cycle with out_valid=1 and out_ready=1.
REQ-018 SEND_LEN SHALL drive out=captured length, out_valid=1; on transfer, go to SEND_DATA with index=0, or to FIN/SEND_SUM when the length is 0.
REQ-019 SEND_DATA SHALL drive out=vector[index], out_valid=1; on transfer, index increments; the transfer at index=length-1 moves to SEND_SUM (macro defined) or FIN.
REQ-020 While out_valid=1 and out_ready=0, out and out_valid SHALL hold unchanged.
REQ-021 FIN SHALL drive done=1 and out_valid=0 for exactly one cycle, then return to IDLE.
REQ-022 start outside IDLE SHALL be ignored; later changes to in/in_len SHALL not affect a transfer in progress.
REQ-023 Minimum latency from start to the first beat is 1 cycle; a transfer of L elements with out_ready held high takes L+1 beats (L+2 with the checksum), plus FIN.
REQ-024 In IDLE and FIN, out SHALL be 0.
REQ-025 The index SHALL be $clog2(N)+1 bits wide so that length=N never wraps.

Reset
REQ-026 rst=1 SHALL force IDLE, out=0, out_valid=0, busy=0, done=0, len_err=0, index=0 and length=0 on the next edge, including mid-transfer; a partial stream is abandoned with no done.
REQ-027 The snapshot vector SHALL be cleared to 0 on rst.

Configuration
REQ-028 With VEC_SERIAL_OUT_CHECKSUM_EN defined, SEND_SUM SHALL follow the last data beat (or SEND_LEN when the length is 0) and emit one beat: the XOR of the length byte and all transferred elements.
REQ-029 Without VEC_SERIAL_OUT_CHECKSUM_EN, the SEND_SUM state and XOR accumulator SHALL be absent and the stream ends after the last data beat.

Structure
REQ-030 The shared package vec_pkg SHALL hold the BITS/N defaults and the FSM state enum type vec_ser_state_t.
REQ-031 This block is a single module and SHALL have no sub-module; the XOR accumulator is inline.

Verification
REQ-032 in_len=3, in={5,6,7,...}, start pulse, out_ready=1 -> beats 3,5,6,7 on consecutive cycles, then done for 1 cycle, then busy=0.
REQ-033 in_len=2, out_ready toggled 1,0,0,1,1 -> each beat held stable while stalled; stream 2,a,b is delivered with no beat lost or duplicated.
REQ-034 in_len=0 -> single beat 0, then done; with the macro defined, beats 0,0.
REQ-035 in_len=N+5 -> length beat N, N data beats, len_err=1 held until rst.
REQ-036 rst asserted after the second data beat -> next cycle out_valid=0, busy=0, no done; a new start then begins cleanly with the length beat.
REQ-037 Macro defined, in_len=2, in={0x0F,0xF0} -> beats 2,0x0F,0xF0,0xFD; start and in changed mid-stream -> output unaffected.
